// File: rtl/accel_motion_integrator_if.sv
// Command/telemetry bundle between the key decoder, the motion integrator
// and its consumers (sprite renderer, HEX speed display).
interface accel_motion_integrator_if #(
  parameter int POS_W = 9
);
  logic [1:0]       accel_i;
  logic             enable_i;
  logic signed [5:0] velocity_o;
  logic [POS_W-1:0] position_o;
  logic             tick_o;
  logic             wrap_o;
  logic             moving_o;
  logic             direction_o;

  modport master (
    output accel_i, enable_i,
    input  velocity_o, position_o, tick_o, wrap_o, moving_o, direction_o
  );

  modport slave (
    input  accel_i, enable_i,
    output velocity_o, position_o, tick_o, wrap_o, moving_o, direction_o
  );
endinterface

// File: rtl/accel_motion_integrator.sv
// Frame-rate motion integrator: turns the decoded accel command into a
// saturating signed velocity with friction decay and a wrapping position.
module accel_motion_integrator #(
  parameter int TICK_DIV       = 833333,
  parameter int VEL_MAX        = 15,
  parameter int POS_W          = 9,
  parameter int POS_MAX        = 319,
  parameter int FRICTION_TICKS = 4
) (
  input logic                      CLOCK_50,
  input logic                      reset,
  accel_motion_integrator_if.slave bus
);

  localparam int CNT_W  = $clog2(TICK_DIV);
  localparam int FRIC_W = $clog2(FRICTION_TICKS + 1);
  localparam int SUM_W  = POS_W + 2;

  localparam logic [CNT_W-1:0]        CNT_LAST  = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0]        CNT_PRE   = CNT_W'(TICK_DIV - 2);
  localparam logic [FRIC_W-1:0]       FRIC_LAST = FRIC_W'(FRICTION_TICKS - 1);
  localparam logic signed [SUM_W-1:0] POS_MAX_S = SUM_W'(POS_MAX);
  localparam logic [POS_W-1:0]        POS_SPAN  = POS_W'(POS_MAX + 1);
  localparam logic signed [5:0]       VEL_POS   = 6'(VEL_MAX);
  localparam logic signed [5:0]       VEL_NEG   = 6'(-VEL_MAX);

  typedef enum logic [1:0] {
    ACCEL_COAST = 2'b00,
    ACCEL_BACK  = 2'b01,
    ACCEL_FWD   = 2'b10,
    ACCEL_IDLE  = 2'b11
  } accelCmdT;

  logic [CNT_W-1:0]  tickCnt_q, tickCnt_d;
  logic              tick_q, tick_d;
  accelCmdT          accel_q, accel_d;
  logic [FRIC_W-1:0] fric_q, fric_d;
  logic signed [5:0] vel_q, vel_d;
  logic [POS_W-1:0]  pos_q, pos_d;
  logic              wrap_q, wrap_d;

  logic                    update;
  logic signed [SUM_W-1:0] posSum;
  logic [POS_W-1:0]        posNext;
  logic                    wrapHit;
  logic signed [5:0]       velNext;
  logic [FRIC_W-1:0]       fricNext;

  // The strobe is decoded one count early so tick itself comes straight
  // from a flop and is high exactly while the counter sits at its last value.
  always_comb begin
    tickCnt_d = (tickCnt_q == CNT_LAST) ? '0 : tickCnt_q + 1'b1;
    tick_d    = (tickCnt_q == CNT_PRE);
    accel_d   = accelCmdT'(bus.accel_i);
    update    = tick_q & bus.enable_i;
  end

  // Position advances by the velocity held before this update; the wrap
  // correction is applied modulo 2^POS_W on the low bits only.
  always_comb begin
    posSum  = $signed({2'b00, pos_q}) + SUM_W'(vel_q);
    posNext = posSum[POS_W-1:0];
    wrapHit = 1'b0;
    if (posSum[SUM_W-1]) begin
      posNext = posSum[POS_W-1:0] + POS_SPAN;
      wrapHit = 1'b1;
    end else if (posSum > POS_MAX_S) begin
      posNext = posSum[POS_W-1:0] - POS_SPAN;
      wrapHit = 1'b1;
    end
  end

  always_comb begin
    velNext  = vel_q;
    fricNext = fric_q;
    unique case (accel_q)
      ACCEL_FWD: begin
        fricNext = '0;
        if (vel_q < VEL_POS) velNext = vel_q + 6'sd1;
      end
      ACCEL_BACK: begin
        fricNext = '0;
        if (vel_q > VEL_NEG) velNext = vel_q - 6'sd1;
      end
      default: begin
        if (fric_q == FRIC_LAST) begin
          fricNext = '0;
          if (vel_q > 6'sd0)      velNext = vel_q - 6'sd1;
          else if (vel_q < 6'sd0) velNext = vel_q + 6'sd1;
        end else begin
          fricNext = fric_q + 1'b1;
        end
      end
    endcase
  end

  // A disabled tick freezes everything, including the friction count.
  always_comb begin
    vel_d  = update ? velNext  : vel_q;
    pos_d  = update ? posNext  : pos_q;
    fric_d = update ? fricNext : fric_q;
    wrap_d = update & wrapHit;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      tickCnt_q <= '0;
      tick_q    <= 1'b0;
      accel_q   <= ACCEL_COAST;
      fric_q    <= '0;
      vel_q     <= '0;
      pos_q     <= '0;
      wrap_q    <= 1'b0;
    end else begin
      tickCnt_q <= tickCnt_d;
      tick_q    <= tick_d;
      accel_q   <= accel_d;
      fric_q    <= fric_d;
      vel_q     <= vel_d;
      pos_q     <= pos_d;
      wrap_q    <= wrap_d;
    end
  end

  assign bus.velocity_o  = vel_q;
  assign bus.position_o  = pos_q;
  assign bus.tick_o      = tick_q;
  assign bus.wrap_o      = wrap_q;
  assign bus.moving_o    = |vel_q;
  assign bus.direction_o = vel_q[5];

endmodule

// File: doc/accel_motion_integrator.md
Name: accel_motion_integrator

Overview:
- Sits directly downstream of the PS/2 key decoder and consumes its 2-bit accel command: 2'b10 = forward, 2'b01 = backward, 2'b00 = released.
- Converts the command into a signed velocity and a wrapping screen position.
- Updates once per frame tick, with saturation and friction decay.
- Feeds the VGA sprite renderer and HEX speed display.

Parameters:
- TICK_DIV, 833333: CLOCK_50 cycles per update tick (60 Hz). Must be ≥ 2.
- VEL_MAX, 15: velocity magnitude limit. Must be ≤ 31.
- POS_W, 9: position width in bits.
- POS_MAX, 319: largest legal position. Positions wrap modulo POS_MAX+1. Must be < 2^POS_W.
- FRICTION_TICKS, 4: consecutive coast ticks per one-step velocity decay toward 0. Must be ≥ 1.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high.
- accel  in  2  command from key decoder: 10 fwd, 01 back, 00/11 coast.
- enable  in  1  1 = updates allowed; 0 = freeze velocity, position and friction count.
- velocity  out  6  signed two's-complement velocity, range −VEL_MAX..+VEL_MAX.
- position  out  POS_W  current position, 0..POS_MAX.
- tick  out  1  one-cycle strobe marking the update cycle.
- wrap  out  1  one-cycle pulse when the position update crossed a boundary.
- moving  out  1  high when velocity ≠ 0.
- direction  out  1  1 = velocity < 0, else 0.

Behaviour:
- Reset:
  - Synchronous, effective on the first edge with reset=1.
  - Clears tick counter, friction counter, velocity, position, tick, wrap and the registered accel to 0.
  - As a result, moving=0 and direction=0.
  - Reset asserted mid-run discards any pending update. The first tick after release occurs TICK_DIV cycles after reset deasserts.
- Tick generator:
  - Counter runs 0..TICK_DIV−1 and wraps to 0.
  - tick=1 for exactly the cycle in which the counter equals TICK_DIV−1, registered and glitch-free.
  - The counter runs regardless of enable.
- accel is registered once every cycle. The update uses the registered value.
- Update (on tick with enable=1), single cycle:
  - Position uses the OLD velocity: new_pos = pos + vel_old.
  - Arithmetic is done in POS_W+2-bit signed.
  - If new_pos > POS_MAX: subtract POS_MAX+1 and set wrap=1.
  - If new_pos < 0: add POS_MAX+1 and set wrap=1.
  - Velocity command rules:
    - accel=10: vel = min(vel+1, +VEL_MAX); friction counter cleared.
    - accel=01: vel = max(vel−1, −VEL_MAX); friction counter cleared.
    - accel=00 or 11: friction counter increments. When it reaches FRICTION_TICKS, vel steps one toward 0 and the counter clears.
    - If vel is already 0, the counter still clears but vel stays 0.
  - Position and velocity outputs change on the edge ending the tick cycle. wrap is valid in the cycle after tick, for one cycle.
- Tick with enable=0:
  - No state changes, wrap=0.
  - The friction counter holds and does not reset.
- Saturation: holding a direction at ±VEL_MAX leaves vel unchanged with no overflow.
- Reversal: accel=01 with vel>0 decelerates by 1 per tick through 0 to negative. There is no instant reversal.
- Outputs are fully registered or derived from registered state. There are no combinational paths from accel to any output.

Test Plan (bench uses TICK_DIV=4, VEL_MAX=15, POS_MAX=319, POS_W=9, FRICTION_TICKS=4):
1. Reset release, enable=1, accel=00 for 40 cycles:
   - First tick strobe appears on the 4th cycle after release.
   - velocity=0, position=0, wrap never asserts, moving=0.
2. accel=10 held for 20 ticks:
   - velocity after n ticks = min(n,15); saturates at 15 on tick 15 and stays there.
   - position after 3 ticks = 3 (0+1+2); after 16 ticks = 120.
3. Forward wrap, preload by driving to velocity=15, position=310:
   - Next tick gives position=5, with wrap pulse for exactly one cycle.
4. Backward wrap, velocity=−3, position=2, accel=01:
   - Next tick gives position=319, wrap=1, velocity=−4, direction=1.
5. Friction, velocity=5, accel=00:
   - velocity=5 through tick 3; 4 at tick 4; 3 at tick 8.
   - Pressing accel=10 at tick 6 clears the count: velocity=5 at tick 6, and the decay restarts.
6. Freeze and reset:
   - enable=0 for 10 ticks with accel=10: velocity and position unchanged, tick still pulses.
   - Asserting reset for 1 cycle mid-run zeroes all outputs on that edge, and the tick phase restarts.
